// File: rtl/config_stream_loader.sv
// Serial configuration-chain loader: accepts host words over a valid/ready handshake and
// shifts them LSB first onto ConfigOut, one bit per cycle, with a matching chain clock-enable.
module config_stream_loader #(
  parameter int unsigned CHAIN_LEN = 5,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ConfigOut,
  output logic              cfg_shift,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bit_count
);

  localparam int unsigned NumWords = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LastBits = CHAIN_LEN - WORD_W * (NumWords - 1);
  localparam int unsigned IdxW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WCntW    = $clog2(NumWords + 1);

  localparam logic [IdxW-1:0] FullLastIdx  = IdxW'(WORD_W - 1);
  localparam logic [IdxW-1:0] FinalLastIdx = IdxW'(LastBits - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [IdxW-1:0]    bit_idx_q, bit_idx_d;
  // Words still to be accepted in this load; zero means the word in flight is the final one.
  logic [WCntW-1:0]   words_left_q, words_left_d;
  logic [15:0]        bit_count_q, bit_count_d;

  logic final_word;
  logic last_bit;
  logic accept;
  logic launch;

  assign final_word = (words_left_q == '0);
  assign last_bit   = (bit_idx_q == (final_word ? FinalLastIdx : FullLastIdx));
  assign accept     = word_valid & word_ready;
  assign launch     = start & ((state_q == StIdle) | (state_q == StDone));
  assign bit_count  = bit_count_q;

  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (last_bit) begin
          if (final_word) begin
            state_d = StDone;
          end else if (!accept) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    cfg_shift  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StLoad: begin
        busy       = 1'b1;
        word_ready = 1'b1;
      end
      StShift: begin
        busy       = 1'b1;
        cfg_shift  = 1'b1;
        // Prefetch the next word on the last bit so the chain sees no bubble.
        word_ready = last_bit & ~final_word;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
    ConfigOut = cfg_shift & word_q[bit_idx_q];
  end

  // The word register only loads on a handshake; bits are picked out by index.
  always_comb begin
    word_d       = word_q;
    bit_idx_d    = bit_idx_q;
    words_left_d = words_left_q;
    bit_count_d  = bit_count_q;
    if (launch) begin
      bit_idx_d    = '0;
      words_left_d = WCntW'(NumWords);
      bit_count_d  = '0;
    end
    if (cfg_shift) begin
      bit_idx_d = bit_idx_q + IdxW'(1);
      if (bit_count_q != 16'hFFFF) bit_count_d = bit_count_q + 16'd1;
    end
    if (accept) begin
      word_d       = word_in;
      bit_idx_d    = '0;
      words_left_d = words_left_q - WCntW'(1);
    end
  end

  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      word_q       <= '0;
      bit_idx_q    <= '0;
      words_left_q <= '0;
      bit_count_q  <= '0;
    end else begin
      word_q       <= word_d;
      bit_idx_q    <= bit_idx_d;
      words_left_q <= words_left_d;
      bit_count_q  <= bit_count_d;
    end
  end

endmodule
